// File: rtl/pid_derivative_term_if.sv
// Sample/result bundle between the servo error source and the D-term stage.
// master drives the sample and strobe and reads the product. slave is the D-term block.
interface pid_derivative_term_if #(
    parameter int cant_bits = 13
);
    logic signed [cant_bits-1:0]   Pot;
    logic                          Rx_En;
    logic signed [2*cant_bits-1:0] R_Mul_D;

    modport master (output Pot, output Rx_En, input R_Mul_D);
    modport slave  (input Pot, input Rx_En, output R_Mul_D);
endinterface

// File: rtl/pid_derivative_term.sv
// PID derivative term: saturated first difference of the error sample, multiplied by KD
// with a sequential shift-add multiplier.
//
//  state  | meaning
//  IDLE   | waiting for Rx_En; capture sample, load multiplier operands
//  MUL    | one shift-add step per cycle, cant_bits steps
//  DONE   | apply sign and register the product on R_Mul_D
module pid_derivative_term #(
    parameter int                          cant_bits = 13,
    parameter logic signed [cant_bits-1:0] KD        = 13'sd3
) (
    input  logic                  Clk_G,
    input  logic                  Rst_G,
    pid_derivative_term_if.slave  bus
);
    localparam int N  = cant_bits;
    localparam int CW = $clog2(N + 1);
    localparam logic [N-1:0]  KD_MAG   = KD[N-1] ? N'(-KD) : N'(KD);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t                state_q;
    logic signed [N-1:0]   prev_q;
    logic signed [N-1:0]   diff_q;
    logic [2*N-1:0]        mcand_q;
    logic [2*N-1:0]        acc_q;
    logic [N-1:0]          mplier_q;
    logic [CW-1:0]         cnt_q;
    logic signed [2*N-1:0] r_mul_q;

    logic signed [N:0]     sub_d;
    logic signed [N-1:0]   diff_d;
    logic [N-1:0]          diff_mag_d;

    always_comb begin
        sub_d = {bus.Pot[N-1], bus.Pot} - {prev_q[N-1], prev_q};
        if (sub_d[N] != sub_d[N-1])
            diff_d = sub_d[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        else
            diff_d = sub_d[N-1:0];
        // -(-2^(N-1)) wraps to the same bit pattern, which reads correctly as unsigned 2^(N-1)
        diff_mag_d = diff_d[N-1] ? N'(-diff_d) : N'(diff_d);
    end

    always_ff @(posedge Clk_G or posedge Rst_G) begin
        if (Rst_G) begin
            state_q  <= S_IDLE;
            prev_q   <= '0;
            diff_q   <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            r_mul_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.Rx_En) begin
                        diff_q   <= diff_d;
                        prev_q   <= bus.Pot;
                        mcand_q  <= {{N{1'b0}}, diff_mag_d};
                        mplier_q <= KD_MAG;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (mplier_q[0])
                        acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST)
                        state_q <= S_DONE;
                end
                S_DONE: begin
                    // diff_q keeps the captured sign, so it doubles as the result-sign record
                    r_mul_q <= (diff_q[N-1] ^ KD[N-1]) ? -acc_q : acc_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.R_Mul_D = r_mul_q;
endmodule

// File: tb/tb_pid_derivative_term.sv
// Directed and randomized bench for pid_derivative_term against an arithmetic
// model of KD * sat13(Pot[j] - Pot[j-1]).
module tb_pid_derivative_term;
    localparam int N     = 13;
    localparam int KD_TB = 3;

    logic Clk_G = 1'b0;
    logic Rst_G = 1'b1;

    pid_derivative_term_if #(.cant_bits(N)) bus ();

    pid_derivative_term #(.cant_bits(N), .KD(13'sd3)) dut (
        .Clk_G (Clk_G),
        .Rst_G (Rst_G),
        .bus   (bus.slave)
    );

    always #5 Clk_G = ~Clk_G;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    int prev_m   = 0;
    int last_out = 0;

    function automatic int sat13(input int v);
        if (v > 4095)  return 4095;
        if (v < -4096) return -4096;
        return v;
    endfunction

    task automatic check(input string tag, input logic signed [2*N-1:0] obs, input int exp_i);
        logic signed [2*N-1:0] exp_v;
        exp_v = (2*N)'(exp_i);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk_G);
        Rst_G = 1'b1;
        repeat (2) @(negedge Clk_G);
        Rst_G = 1'b0;
        prev_m   = 0;
        last_out = 0;
    endtask

    // Strobe one sample, check the output is unchanged at edge 13 and updated at edge 14,
    // then pad so the next capture lands 16 cycles after this one.
    task automatic strobe(input logic signed [N-1:0] pot, input string tag);
        int exp_r;
        exp_r  = KD_TB * sat13(int'(pot) - prev_m);
        prev_m = int'(pot);
        @(negedge Clk_G);
        bus.Pot   = pot;
        bus.Rx_En = 1'b1;
        @(posedge Clk_G);
        #1 bus.Rx_En = 1'b0;
        repeat (13) @(posedge Clk_G);
        #1 check({tag, "_e13"}, bus.R_Mul_D, last_out);
        @(posedge Clk_G);
        #1 check({tag, "_e14"}, bus.R_Mul_D, exp_r);
        last_out = exp_r;
        @(posedge Clk_G);
    endtask

    initial begin
        logic signed [N-1:0] rnd;
        bus.Pot   = '0;
        bus.Rx_En = 1'b0;

        // reset held with strobes pulsing
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk_G);
            bus.Pot   = 13'sd777;
            bus.Rx_En = i[0];
            #2 check("rst_hold", bus.R_Mul_D, 0);
        end
        @(negedge Clk_G);
        bus.Rx_En = 1'b0;
        Rst_G     = 1'b0;
        repeat (20) @(posedge Clk_G);
        #1 check("rst_idle", bus.R_Mul_D, 0);

        // basic
        strobe(13'sd100, "basic_100");
        strobe(13'sd40,  "basic_40");

        // saturation at both rails
        strobe(-13'sd4096, "sat_m4096a");
        strobe(13'sd4095,  "sat_p4095");
        strobe(-13'sd4096, "sat_m4096b");

        // busy rejection: re-strobe at edge 5 is dropped
        do_reset();
        @(negedge Clk_G);
        bus.Pot   = 13'sd50;
        bus.Rx_En = 1'b1;
        @(posedge Clk_G);
        #1 bus.Rx_En = 1'b0;
        repeat (4) @(posedge Clk_G);
        @(negedge Clk_G);
        bus.Pot   = 13'sd1000;
        bus.Rx_En = 1'b1;
        @(posedge Clk_G);
        #1 bus.Rx_En = 1'b0;
        repeat (8) @(posedge Clk_G);
        #1 check("busy_e13", bus.R_Mul_D, 0);
        @(posedge Clk_G);
        #1 check("busy_e14", bus.R_Mul_D, 150);
        prev_m   = 50;
        last_out = 150;
        @(posedge Clk_G);
        strobe(13'sd60, "busy_next");

        // reset in the middle of a multiply
        @(negedge Clk_G);
        bus.Pot   = 13'sd200;
        bus.Rx_En = 1'b1;
        @(posedge Clk_G);
        #1 bus.Rx_En = 1'b0;
        repeat (7) @(posedge Clk_G);
        #1 Rst_G = 1'b1;
        #1 check("midrst_clear", bus.R_Mul_D, 0);
        @(negedge Clk_G);
        Rst_G    = 1'b0;
        prev_m   = 0;
        last_out = 0;
        repeat (12) @(posedge Clk_G);
        #1 check("midrst_hold", bus.R_Mul_D, 0);
        strobe(13'sd10, "midrst_next");

        // random regression from a fresh reset
        do_reset();
        for (int j = 0; j < 101; j++) begin
            rnd = 13'($urandom_range(0, 8191));
            strobe(rnd, $sformatf("rand_%0d", j));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pid_derivative_term.md
# pid_derivative_term

Derivative (D) term of the servo PID controller. On each sample strobe it captures the signed error sample `Pot` and forms the first difference against the previous sample, saturated to N bits. It multiplies that difference by the derivative gain `KD` using a sequential shift-add multiplier and presents the exact 2N-bit signed product on `R_Mul_D`. Its output feeds the PID summation stage alongside the P and I terms.

## Interface
- `cant_bits`, default 13: sample width N; all widths below derive from it.
- `KD`, default 13'sd3: signed N-bit derivative gain, constant.
- `Clk_G`  in  1: system clock; all state changes on the rising edge.
- `Rst_G`  in  1: reset, asynchronous and active-high.
- `Pot`  in  N (signed): error sample; valid on the cycle `Rx_En` is high.
- `Rx_En`  in  1: single-cycle sample strobe.
- `R_Mul_D`  out  2N (signed): registered D-term product; holds its value between updates.

## Operation
- State machine: IDLE, MUL, DONE.
- Internal registers:
  - `prev`: N-bit signed, last accepted sample.
  - `diff`: N-bit signed.
  - Multiplier operands: magnitudes, accumulator, step counter, result sign.
- IDLE: on a rising edge with `Rx_En`=1, the block accepts the sample.
  - `diff` <= sat_N(`Pot` − `prev`). The subtraction is done at N+1 bits, then clamped to [−2^(N−1), 2^(N−1)−1].
  - `prev` <= `Pot`.
  - Load |diff| and |KD| as N-bit unsigned magnitudes. The magnitude 2^(N−1) is representable.
  - Record sign = sign(diff) XOR sign(KD).
  - Clear the accumulator and counter, then go to MUL.
- MUL: one shift-add step per cycle, exactly N cycles. In each step, if the current multiplier LSB is 1, add the shifted multiplicand to the 2N-bit accumulator. After step N, go to DONE.
- DONE: `R_Mul_D` <= sign ? −acc : acc, then return to IDLE.
- The product is exact: no overflow is possible in 2N bits.
- `Rx_En` is ignored in MUL and DONE. The sample is dropped and `prev` is not updated.
- First sample after reset differences against `prev`=0, so the product equals KD·`Pot`.
- A zero difference, or KD=0, yields 0.

## Timing
- Reset (async, any time including mid-multiply):
  - `R_Mul_D`=0, `prev`=0, state IDLE.
  - Accumulator, counter and `diff` cleared.
  - An in-flight result is discarded.
- Latency: let the capture edge be edge 0. Edges 1..N perform the multiply steps. `R_Mul_D` updates on edge N+1, which is 14 for N=13. The block is back in IDLE after edge N+1.
- `R_Mul_D` is stable from edge N+1 until the next update. Any strobe spaced ≥ N+2 cycles apart is accepted; the system strobes every 16 cycles.
- A strobe on the same edge the block returns to IDLE (edge N+1) is ignored. The earliest accepted strobe is edge N+2.
- No combinational path from inputs to `R_Mul_D`.

## Test plan
- Reset: hold `Rst_G`=1 with `Rx_En` pulsing -> `R_Mul_D`=0 throughout. After release with no strobe, output stays 0.
- Basic: after reset, strobe `Pot`=100, then `Pot`=40, 16 cycles apart.
  - After the first strobe, `R_Mul_D`=300 at edge 14 and it is not yet updated at edge 13.
  - After the second strobe, `R_Mul_D`=−180.
- Saturation: strobe `Pot`=−4096, then 4095, then −4096.
  - diff clamps to 4095, giving 12285.
  - diff clamps to −4096, giving −12288.
- Busy rejection: strobe `Pot`=50, then re-strobe `Pot`=1000 at edge 5.
  - Result is 150 at edge 14.
  - A following strobe of 60 gives 30, since `prev` stays 50.
- Mid-operation reset: strobe `Pot`=200, then assert `Rst_G` at edge 7 and release.
  - `R_Mul_D` stays 0.
  - Next strobe `Pot`=10 gives 30, since `prev`=0.
- Random regression: 101 random N-bit samples, strobed every 16 cycles. Compare `R_Mul_D` against the model KD·sat_N(`Pot`[j] − `Pot`[j−1]), with `Pot`[−1]=0.
